debug_trace_capture: RTL

//  Parametrised multi-channel debug capture unit; successor to the single-register debug latch.
//  - Samples one selected channel into a circular trace buffer while test_mode is high.
//  - Stops on a programmable trigger plus a fixed post-trigger window.
//  - Drains the buffer oldest-first over a valid/ready port.
//  - Sits at chip top beside the processing IP; its data/status buses are the observed channels.

---
 rtl/debug_trace_pkg.sv | 29 ++
 rtl/debug_trace_ram.sv | 26 ++
 rtl/debug_trace_capture.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/debug_trace_pkg.sv
// Shared types and constants for the debug trace capture unit.
package debug_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_READ  = 2'd3
   } trace_state_e;

   localparam logic [1:0] TRIG_NONE = 2'd0;
   localparam logic [1:0] TRIG_EQ   = 2'd1;
   localparam logic [1:0] TRIG_CHG  = 2'd2;
   localparam logic [1:0] TRIG_IMM  = 2'd3;

   function automatic logic trig_hit(input logic [1:0] mode, input logic is_eq,
                                     input logic is_chg, input logic is_first);
      logic hit;
      case (mode)
         TRIG_NONE: hit = 1'b0;
         TRIG_EQ:   hit = is_eq;
         TRIG_CHG:  hit = is_chg;
         TRIG_IMM:  hit = is_first;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/debug_trace_ram.sv
// Trace storage: synchronous write, combinational read; no reset on the array.
module debug_trace_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              sys_clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Write port
   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/debug_trace_capture.sv
// Multi-channel debug capture: circular trace of one channel, trigger + post window,
// oldest-first drain over a valid/ready port.
module debug_trace_capture
   import debug_trace_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int NUM_CH       = 4,
   parameter int DEPTH        = 16,
   parameter int POST_SAMPLES = 4,
   localparam int CH_W   = $clog2(NUM_CH),
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     test_mode,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [CH_W-1:0]          ch_sel,
   input  logic [1:0]               trig_mode,
   input  logic [DATA_W-1:0]        trig_value,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_last,
   output logic [1:0]               state_o,
   output logic                     wrapped,
   output logic [DATA_W-1:0]        debug_output
);

   trace_state_e      state_r;
   logic              tm_r;
   logic [CH_W-1:0]   sel_r;
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  post_cnt_r;
   logic [CNT_W-1:0]  rd_idx_r;
   logic [DATA_W-1:0] prev_r;
   logic              prev_vld_r;
   logic              rd_valid_r;
   logic              rd_last_r;
   logic [DATA_W-1:0] rd_data_r;
   logic              wrapped_r;
   logic [DATA_W-1:0] dbg_r;

   logic [DATA_W-1:0] ch_arr_s [NUM_CH];
   logic [DATA_W-1:0] sample_s;
   logic              accept_s;
   logic              hit_s;
   logic [CNT_W-1:0]  rd_idx_nxt_s;
   logic [ADDR_W-1:0] rd_addr_s;
   logic              last_nxt_s;
   logic [DATA_W-1:0] ram_rd_s;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign ch_arr_s[k] = ch_data[k*DATA_W +: DATA_W];
   end

   assign sample_s = ch_arr_s[sel_r];
   assign accept_s = ((state_r == ST_ARMED) || (state_r == ST_POST)) && ch_valid[sel_r];
   assign hit_s    = trig_hit(trig_mode, sample_s == trig_value,
                              prev_vld_r && (sample_s != prev_r), !prev_vld_r);

   // While a word is presented, the RAM already looks up the one after it.
   assign rd_idx_nxt_s = rd_valid_r ? (rd_idx_r + CNT_W'(1)) : rd_idx_r;
   assign rd_addr_s    = wr_ptr_r - count_r[ADDR_W-1:0] + rd_idx_nxt_s[ADDR_W-1:0];
   assign last_nxt_s   = (rd_idx_nxt_s == (count_r - CNT_W'(1)));

   debug_trace_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .sys_clk (sys_clk),
      .wr_en   (accept_s),
      .wr_addr (wr_ptr_r),
      .wr_data (sample_s),
      .rd_addr (rd_addr_s),
      .rd_data (ram_rd_s)
   );

   // Capture FSM, write pointer bookkeeping and readout skid register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r    <= ST_IDLE;
         tm_r       <= 1'b0;
         sel_r      <= '0;
         wr_ptr_r   <= '0;
         count_r    <= '0;
         post_cnt_r <= '0;
         rd_idx_r   <= '0;
         prev_r     <= '0;
         prev_vld_r <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_last_r  <= 1'b0;
         rd_data_r  <= '0;
         wrapped_r  <= 1'b0;
         dbg_r      <= '0;
      end else begin
         tm_r <= test_mode;
         // A write still lands when test_mode falls in the same cycle.
         if (accept_s) begin
            wr_ptr_r   <= wr_ptr_r + ADDR_W'(1);
            count_r    <= (count_r == CNT_W'(DEPTH)) ? count_r : (count_r + CNT_W'(1));
            wrapped_r  <= wrapped_r | (count_r == CNT_W'(DEPTH));
            dbg_r      <= sample_s;
            prev_r     <= sample_s;
            prev_vld_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (test_mode && !tm_r) begin
                  state_r    <= ST_ARMED;
                  sel_r      <= ch_sel;
                  wr_ptr_r   <= '0;
                  count_r    <= '0;
                  post_cnt_r <= '0;
                  rd_idx_r   <= '0;
                  prev_r     <= '0;
                  prev_vld_r <= 1'b0;
                  wrapped_r  <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (!test_mode) begin
                  state_r <= ST_IDLE;
               end else if (accept_s && hit_s) begin
                  if (POST_SAMPLES == 0) begin
                     state_r <= ST_READ;
                  end else begin
                     state_r <= ST_POST;
                  end
               end
            end
            ST_POST: begin
               if (!test_mode) begin
                  state_r <= ST_IDLE;
               end else if (accept_s) begin
                  post_cnt_r <= post_cnt_r + CNT_W'(1);
                  if ((post_cnt_r + CNT_W'(1)) == CNT_W'(POST_SAMPLES)) begin
                     state_r <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (!test_mode) begin
                  state_r    <= ST_IDLE;
                  rd_valid_r <= 1'b0;
                  rd_last_r  <= 1'b0;
               end else if (rd_valid_r && rd_ready && rd_last_r) begin
                  state_r    <= ST_IDLE;
                  rd_valid_r <= 1'b0;
                  rd_last_r  <= 1'b0;
               end else if (!rd_valid_r || rd_ready) begin
                  rd_valid_r <= 1'b1;
                  rd_idx_r   <= rd_idx_nxt_s;
                  rd_data_r  <= ram_rd_s;
                  rd_last_r  <= last_nxt_s;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               rd_valid_r <= 1'b0;
               rd_last_r  <= 1'b0;
            end
         endcase
      end
   end

   assign rd_valid     = rd_valid_r;
   assign rd_data      = rd_data_r;
   assign rd_last      = rd_last_r;
   assign state_o      = state_r;
   assign wrapped      = wrapped_r;
   assign debug_output = dbg_r;

endmodule
